// File: rtl/con_pkg.sv
// con_pkg: condition codes, FSM states and C2 field width for the branch-condition unit
package con_pkg;
  localparam int C2_W = 4;
  localparam logic [C2_W-1:0] COND_ZERO    = 4'd0;
  localparam logic [C2_W-1:0] COND_NONZERO = 4'd1;
  localparam logic [C2_W-1:0] COND_GE      = 4'd2;
  localparam logic [C2_W-1:0] COND_LT      = 4'd3;
  localparam logic [C2_W-1:0] COND_GT      = 4'd4;
  localparam logic [C2_W-1:0] COND_LE      = 4'd5;
  localparam logic [C2_W-1:0] COND_ALWAYS  = 4'd6;
  localparam logic [C2_W-1:0] COND_NEVER   = 4'd7;
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
endpackage

// File: rtl/con_eval.sv
// con_eval: combinational evaluation of a 4-bit condition code against a signed operand
module con_eval
  import con_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [C2_W-1:0]   c2,
  input  logic [DATA_W-1:0] operand,
  output logic              taken,
  output logic              illegal
);
  logic zero, neg;
  assign zero = ~|operand;
  assign neg = operand[DATA_W-1];
  assign illegal = c2[C2_W-1];
  always_comb begin
    taken = 1'b0;
    case (c2)
      COND_ZERO:    taken = zero;
      COND_NONZERO: taken = ~zero;
      COND_GE:      taken = ~neg;
      COND_LT:      taken = neg;
      COND_GT:      taken = ~neg & ~zero;
      COND_LE:      taken = neg | zero;
      COND_ALWAYS:  taken = 1'b1;
      COND_NEVER:   taken = 1'b0;
      default:      taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/con_ff_unit.sv
// con_ff_unit: latches C2 from IR and registers the branch decision on ConIn.
// Optional taken counter enabled by macro CON_HISTORY_EN.
module con_ff_unit
  import con_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int C2_LO  = 19
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              ir_load,
  input  logic [31:0]       IR,
  input  logic              ConIn,
  input  logic [DATA_W-1:0] BusMuxOut,
  output logic              Con,
  output logic              con_valid,
  output logic              illegal
`ifdef CON_HISTORY_EN
  ,
  output logic [15:0]       taken_count
`endif
);
  state_t state, state_n;
  logic [C2_W-1:0] c2_q;
  logic taken, bad, eval;
  logic unused_ir;
  assign unused_ir = ^IR;
  con_eval #(.DATA_W(DATA_W)) u_eval (
    .c2(c2_q),
    .operand(BusMuxOut),
    .taken(taken),
    .illegal(bad)
  );
  // ir_load has priority; ConIn only counts once a condition has been latched
  assign eval = ConIn & ~ir_load & (state != IDLE);
  always_comb begin
    state_n = ir_load ? ARMED : eval ? DONE : state;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      c2_q      <= '0;
      Con       <= 1'b0;
      con_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state <= state_n;
      if (ir_load) begin
        c2_q      <= IR[C2_LO +: C2_W];
        con_valid <= 1'b0;
        illegal   <= 1'b0;
      end else if (eval) begin
        Con       <= taken;
        con_valid <= 1'b1;
        illegal   <= illegal | bad;
      end
    end
  end
`ifdef CON_HISTORY_EN
  always_ff @(posedge clock) begin
    if (clear) taken_count <= '0;
    else if (eval && taken && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_con_ff_unit.sv
// tb_con_ff_unit: randomized and directed checks of con_ff_unit against a behavioural model
module tb_con_ff_unit;
  logic clock = 1'b0;
  logic clear = 1'b0, ir_load = 1'b0, ConIn = 1'b0;
  logic [31:0] IR = '0, BusMuxOut = '0;
  logic Con, con_valid, illegal, con8, valid8, ill8;
  int n_checks = 0, n_fail = 0;
  bit started = 1'b0;
`ifdef CON_HISTORY_EN
  logic [15:0] taken_count, tc8;
`endif

  always #5 clock = ~clock;

  con_ff_unit dut (
    .clock(clock), .clear(clear), .ir_load(ir_load), .IR(IR), .ConIn(ConIn),
    .BusMuxOut(BusMuxOut), .Con(Con), .con_valid(con_valid), .illegal(illegal)
`ifdef CON_HISTORY_EN
    , .taken_count(taken_count)
`endif
  );

  con_ff_unit #(.DATA_W(8)) dut8 (
    .clock(clock), .clear(clear), .ir_load(ir_load), .IR(IR), .ConIn(ConIn),
    .BusMuxOut(BusMuxOut[7:0]), .Con(con8), .con_valid(valid8), .illegal(ill8)
`ifdef CON_HISTORY_EN
    , .taken_count(tc8)
`endif
  );

  // reference model: tracks whether a condition is loaded and the last decision
  bit m_loaded, m_con, m_valid, m_ill;
  int m_c2, m_cnt;

  function automatic bit cond(int c, logic signed [31:0] x);
    case (c)
      0: return x == 0;
      1: return x != 0;
      2: return x >= 0;
      3: return x < 0;
      4: return x > 0;
      5: return x <= 0;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (clear) begin
      m_loaded = 0; m_c2 = 0; m_con = 0; m_valid = 0; m_ill = 0; m_cnt = 0;
    end else if (ir_load) begin
      m_loaded = 1; m_c2 = int'(IR[22:19]); m_valid = 0; m_ill = 0;
    end else if (ConIn && m_loaded) begin
      m_con = cond(m_c2, BusMuxOut);
      m_valid = 1;
      if (m_c2 >= 8) m_ill = 1;
      if (m_con && m_cnt < 65535) m_cnt++;
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      check("con", 32'(Con), 32'(m_con));
      check("con_valid", 32'(con_valid), 32'(m_valid));
      check("illegal", 32'(illegal), 32'(m_ill));
`ifdef CON_HISTORY_EN
      check("taken_count", 32'(taken_count), 32'(m_cnt));
`endif
    end
  end

  task automatic cyc(bit clr, bit ld, logic [3:0] c2, bit ci, logic [31:0] x);
    logic [31:0] ir;
    ir = $urandom;
    ir[22:19] = c2;
    clear = clr; ir_load = ld; IR = ir; ConIn = ci; BusMuxOut = x;
    @(posedge clock);
    #1;
    started = 1'b1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    check("reset_con", 32'(Con), 0);
    check("reset_valid", 32'(con_valid), 0);
    check("reset_illegal", 32'(illegal), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("zero_con", 32'(Con), 1);
    check("zero_valid", 32'(con_valid), 1);
    cyc(0, 1, 3, 0, 0);
    cyc(0, 0, 0, 1, 32'h8000_0000);
    check("lt_neg", 32'(Con), 1);
    cyc(0, 0, 0, 1, 32'h0000_0001);
    check("lt_redo_con", 32'(Con), 0);
    check("lt_redo_valid", 32'(con_valid), 1);
    cyc(0, 1, 3, 0, 0);
    cyc(0, 0, 0, 1, 32'h0000_0080);
    check("lt_pos32", 32'(Con), 0);
    check("lt_neg8", 32'(con8), 1);
    cyc(0, 1, 4, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("gt_zero", 32'(Con), 0);
    cyc(0, 1, 5, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("le_zero", 32'(Con), 1);
    cyc(0, 1, 2, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("ge_zero", 32'(Con), 1);
    cyc(0, 1, 9, 0, 0);
    cyc(0, 0, 0, 1, 5);
    check("c2_9_con", 32'(Con), 0);
    check("c2_9_illegal", 32'(illegal), 1);
    check("c2_9_valid", 32'(con_valid), 1);
    cyc(0, 1, 6, 0, 0);
    check("reload_illegal", 32'(illegal), 0);
    check("reload_valid", 32'(con_valid), 0);
    cyc(0, 0, 0, 1, 0);
    check("always_con", 32'(Con), 1);
    cyc(0, 1, 7, 1, 0);
    check("both_valid", 32'(con_valid), 0);
    check("both_con_hold", 32'(Con), 1);
    cyc(0, 0, 0, 1, 0);
    check("never_con", 32'(Con), 0);
    cyc(0, 1, 6, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("idle_ignore_con", 32'(Con), 0);
    check("idle_ignore_valid", 32'(con_valid), 0);
`ifdef CON_HISTORY_EN
    cyc(0, 1, 6, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, $urandom);
    check("count_3", 32'(taken_count), 3);
    cyc(1, 0, 0, 0, 0);
    check("count_clear", 32'(taken_count), 0);
    cyc(0, 1, 6, 0, 0);
    repeat (65535) cyc(0, 0, 0, 1, 0);
    check("count_full", 32'(taken_count), 32'hFFFF);
    cyc(0, 0, 0, 1, 0);
    check("count_sat", 32'(taken_count), 32'hFFFF);
    cyc(0, 1, 0, 0, 0);
    check("count_keep_on_load", 32'(taken_count), 32'hFFFF);
`endif
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] x;
      int sel;
      sel = $urandom_range(0, 4);
      x = sel == 0 ? 32'h0 : sel == 1 ? 32'h1 : sel == 2 ? 32'h8000_0000 :
          sel == 3 ? 32'hFFFF_FFFF : $urandom;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
          4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, x);
    end
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/con_ff_unit.md
CON_FF_UNIT -- requirements
Module: con_ff_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the bus operand under test.
REQ-002 The block SHALL have parameter C2_LO, default 19, giving the LSB of the 4-bit condition field C2 within IR.
REQ-003 The block SHALL have port clock, input, 1, as the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clear, input, 1, as the reset: synchronous, active-high.
REQ-005 The block SHALL have port ir_load, input, 1, a strobe that latches C2 from IR.
REQ-006 The block SHALL have port IR, input, 32, the instruction register.
REQ-007 The block SHALL have port ConIn, input, 1, a strobe that evaluates the latched condition against BusMuxOut.
REQ-008 The block SHALL have port BusMuxOut, input, DATA_W, the operand.
REQ-009 The block SHALL have port Con, output, 1, the registered branch decision.
REQ-010 The block SHALL have port con_valid, output, 1, high while Con holds a result for the current C2.
REQ-011 The block SHALL have port illegal, output, 1, a sticky flag set when a reserved C2 is evaluated.

Function
REQ-012 The block SHALL use states IDLE, ARMED and DONE.
REQ-013 On ir_load in any state, the block SHALL latch IR[C2_LO+3:C2_LO] into c2_q, go to ARMED, and clear con_valid and illegal on the next edge; Con SHALL hold its value.
REQ-014 On ConIn in ARMED, the block SHALL evaluate and, on the same edge, register Con, set con_valid=1 and go to DONE; latency is 1 cycle.
REQ-015 The block SHALL ignore ConIn in IDLE; outputs are unchanged.
REQ-016 On ConIn in DONE, the block SHALL re-evaluate with the same c2_q against the new BusMuxOut, update Con and stay in DONE.
REQ-017 When ir_load and ConIn are both high, ir_load SHALL win and ConIn SHALL be ignored that cycle.
REQ-018 The block SHALL decode C2, with operand X=BusMuxOut treated as signed, as follows: 0 zero X==0; 1 nonzero X!=0; 2 ge X>=0 (MSB=0); 3 lt X<0 (MSB=1); 4 gt X>0; 5 le X<=0; 6 always 1; 7 never 0.
REQ-019 For C2 values 8-15, the block SHALL produce Con=0 and set illegal=1 (sticky until ir_load or clear); con_valid SHALL still assert.
REQ-020 The zero test SHALL be the NOR of all DATA_W bits, and gt SHALL equal (MSB=0 AND X!=0), for any DATA_W>=2.

Reset
REQ-021 When clear is high at a rising edge, the block SHALL set state=IDLE, c2_q=0, Con=0, con_valid=0 and illegal=0, overriding ir_load and ConIn that cycle.
REQ-022 A clear in ARMED or DONE SHALL abandon the pending condition; a subsequent ConIn without ir_load SHALL be ignored.

Configuration
REQ-023 With macro CON_HISTORY_EN defined, the block SHALL add output taken_count[15:0], which increments on each evaluation producing Con=1, saturates at 16'hFFFF, and resets to 0 on clear only (not on ir_load).
REQ-024 With CON_HISTORY_EN undefined, taken_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package con_pkg SHALL hold the 4-bit condition-code constants (COND_ZERO..COND_NEVER), the state enum, and the C2 field width.
REQ-026 The pure combinational evaluator SHALL be sub-module con_eval (inputs c2 and operand; outputs taken and illegal); con_ff_unit holds the FSM and registers.

Verification
REQ-027 The bench SHALL cover: clear, then ir_load with IR[22:19]=0, then ConIn with BusMuxOut=0 -> next edge Con=1, con_valid=1, state DONE.
REQ-028 The bench SHALL cover: C2=3 armed, ConIn with X=32'h8000_0000 -> Con=1; while in DONE, ConIn with X=32'h0000_0001 -> Con=0, con_valid stays 1.
REQ-029 The bench SHALL cover: C2=4 with X=0 -> Con=0; C2=5 with X=0 -> Con=1; C2=2 with X=0 -> Con=1.
REQ-030 The bench SHALL cover: C2=9 armed then ConIn -> Con=0, illegal=1; ir_load with C2=6 -> illegal=0, con_valid=0; ConIn -> Con=1.
REQ-031 The bench SHALL cover: ir_load and ConIn in the same cycle from DONE -> ARMED, con_valid=0, Con unchanged; ConIn from IDLE after clear -> no change.
REQ-032 The bench SHALL cover: with CON_HISTORY_EN defined and C2=6, 3 ConIn pulses -> taken_count=3; clear -> 0; counter preloaded to 16'hFFFF plus one more taken evaluation -> stays 16'hFFFF; DATA_W=8 run with X=8'h80 and C2=3 -> Con=1.
